dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Sequencing controller and two-port arbiter for the core's byte-addressed data RAM, sitting between the RAM and two requesters: port 0, the core load/store unit, and port 1, the program/debug loader. It grants one transaction at a time, round-robin. Each granted transaction drives a single word-wide RAM access with byte enables, then returns formatted read data (lane select, sign/zero extension) or an error to the granted port.

## Interface
- ADDR_W, 8, byte-address width; RAM word address is ADDR_W-2 bits
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pN_req_valid  in  1  request valid, N in {0,1}; held until accepted
- pN_req_ready  out  1  request accepted this cycle
- pN_req_addr  in  ADDR_W  byte address
- pN_req_size  in  3  one-hot size: 001 byte, 010 half, 100 word
- pN_req_write  in  1  1 store, 0 load
- pN_req_signed  in  1  sign-extend loads; ignored for word and stores
- pN_req_wdata  in  32  store data, right-aligned
- pN_rsp_valid  out  1  one-cycle response pulse
- pN_rsp_rdata  out  32  formatted load data; 0 for stores and errors
- pN_rsp_err  out  1  misaligned or illegal size; qualified by rsp_valid
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write
- mem_addr  out  ADDR_W-2  word address = addr[ADDR_W-1:2]
- mem_be  out  4  byte-lane write enables
- mem_wdata  out  32  lane-steered write data
- mem_rdata  in  32  RAM read word, valid the cycle after mem_en

## Operation
- FSM states: IDLE, MEM, RESP.
- IDLE, no valid: stay.
- IDLE, one valid: grant it.
- IDLE, both valid: grant the port not granted last.
- On grant: assert that port's req_ready combinationally this cycle, latch the request, record last_grant.
- IDLE, latched request legal: go to MEM. Latched request illegal: go straight to RESP with err=1, and no RAM access occurs.
- Illegal: size not one-hot, half with addr[0]=1, word with addr[1:0]≠0.
- MEM: mem_en=1, mem_we=write, mem_addr/mem_be/mem_wdata from the latched request, then go to RESP.
- RESP: rsp_valid=1 for the granted port only, with rdata and err; return to IDLE.
- Store lanes:
  - byte: be=1<<addr[1:0], wdata byte replicated ×4
  - half: be=0011 (addr[1]=0) or 1100, halfword replicated ×2
  - word: be=1111
- Load format, from mem_rdata sampled in RESP:
  - byte: lane addr[1:0], extended to 32 by signed
  - half: lane addr[1], extended to 32 by signed
  - word: passthrough
- mem_be=0000 on loads.

## Timing
- Legal request: accept at cycle T, MEM at T+1, rsp_valid at T+2.
- Illegal request: accept at T, rsp_valid with err at T+1.
- Throughput: one transaction per 3 cycles (2 if illegal). req_ready is never asserted outside IDLE.
- Reset values: state=IDLE, last_grant=1 (port 0 wins first tie). All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_be, mem_wdata.
- Reset mid-operation: transaction dropped, no rsp_valid. A store whose MEM cycle coincides with rst still commits in the RAM.
- A requester deasserting valid before ready is tolerated; no transaction is recorded.

## Structure
- Shared header dmem_defs.vh holds:
  - SIZE_B=3'b001, SIZE_H=3'b010, SIZE_W=3'b100
  - FSM state encodings
- Sub-module dmem_lane_fmt (combinational): store lane steering/byte enables, load lane select/extension, and the legality check. It is reused by any future cache front end.

## Test plan
- p0 load word addr 0x08, RAM word 0xDEADBEEF -> p0 req_ready at T, mem_en/mem_addr=0x02 at T+1, p0 rsp rdata=0xDEADBEEF err=0 at T+2.
- p1 store byte 0xA5 at addr 0x13 -> mem_we=1, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x04; a follow-up signed byte load returns 0xFFFFFFA5, and an unsigned one returns 0x000000A5.
- Both valid every cycle from reset -> grants alternate p0,p1,p0,p1. Each response goes only to its own port, and neither port gets two consecutive grants while the other waits.
- p0 half load at addr 0x05 -> rsp at T+1 with err=1, rdata=0, and mem_en never asserted. Size 3'b011 gives the same result.
- Signed half load addr 0x0E, RAM word 0x80017FFF -> rdata=0xFFFF8001; unsigned gives 0x00008001.
- rst asserted during RESP of a p0 load -> no p0 rsp_valid, all outputs 0 the next cycle, and the next tie grants p0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: access size codes, FSM states,
// and the alignment/size legality rule used by the lane formatter.
package dmem_arbiter_pkg;

    localparam logic [2:0] SIZE_B = 3'b001;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // A request is legal only with a one-hot size and natural alignment.
    function automatic logic is_legal(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            SIZE_B:  is_legal = 1'b1;
            SIZE_H:  is_legal = ~lsb[0];
            SIZE_W:  is_legal = (lsb == 2'b00);
            default: is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: store byte enables and data steering,
// load lane select with sign/zero extension, and the legality check.
module dmem_lane_fmt
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0]  i_lsb,
    input  logic [2:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic        o_legal,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte  = i_rdata[{i_lsb, 3'b000} +: 8];
    assign w_half  = i_lsb[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign o_legal = is_legal(i_size, i_lsb);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'd0;
        o_rdata = 32'd0;
        case (i_size)
            SIZE_B: begin
                o_be    = 4'b0001 << i_lsb;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
            end
            SIZE_H: begin
                o_be    = i_lsb[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{i_signed & w_half[15]}}, w_half};
            end
            SIZE_W: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the byte-addressed data RAM:
// one transaction at a time, IDLE -> MEM -> RESP (illegal requests skip MEM).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [2:0]        p0_req_size,
    input  logic              p0_req_write,
    input  logic              p0_req_signed,
    input  logic [31:0]       p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic [31:0]       p0_rsp_rdata,
    output logic              p0_rsp_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [2:0]        p1_req_size,
    input  logic              p1_req_write,
    input  logic              p1_req_signed,
    input  logic [31:0]       p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic [31:0]       p1_rsp_rdata,
    output logic              p1_rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_last_grant;
    logic              r_port;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_size;
    logic              r_write;
    logic              r_signed;
    logic [31:0]       r_wdata;
    logic              r_err;

    logic              w_idle;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_grant;
    logic [ADDR_W-1:0] w_in_addr;
    logic [2:0]        w_in_size;
    logic              w_in_signed;
    logic [1:0]        w_f_lsb;
    logic [2:0]        w_f_size;
    logic              w_f_signed;
    logic              w_f_legal;
    logic [3:0]        w_f_be;
    logic [31:0]       w_f_wdata;
    logic [31:0]       w_f_rdata;
    logic              w_mem;
    logic              w_store;
    logic              w_rsp;
    logic              w_rsp_data;

    // Port 0 wins a tie only when port 1 held the last grant.
    assign w_idle   = (r_state == ST_IDLE) && !rst;
    assign w_grant0 = w_idle && p0_req_valid && (!p1_req_valid || r_last_grant);
    assign w_grant1 = w_idle && p1_req_valid && !w_grant0;
    assign w_grant  = w_grant0 | w_grant1;

    assign w_in_addr   = w_grant1 ? p1_req_addr   : p0_req_addr;
    assign w_in_size   = w_grant1 ? p1_req_size   : p0_req_size;
    assign w_in_signed = w_grant1 ? p1_req_signed : p0_req_signed;

    // The formatter checks the incoming request in IDLE and serves the latched one afterwards.
    assign w_f_lsb    = (r_state == ST_IDLE) ? w_in_addr[1:0] : r_addr[1:0];
    assign w_f_size   = (r_state == ST_IDLE) ? w_in_size      : r_size;
    assign w_f_signed = (r_state == ST_IDLE) ? w_in_signed    : r_signed;

    dmem_lane_fmt u_lane_fmt (
        .i_lsb    (w_f_lsb),
        .i_size   (w_f_size),
        .i_signed (w_f_signed),
        .i_wdata  (r_wdata),
        .i_rdata  (mem_rdata),
        .o_legal  (w_f_legal),
        .o_be     (w_f_be),
        .o_wdata  (w_f_wdata),
        .o_rdata  (w_f_rdata)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_grant) w_state_next = w_f_legal ? ST_MEM : ST_RESP;
            ST_MEM:  w_state_next = ST_RESP;
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_grant) r_last_grant <= w_grant1;
        end
    end

    // NOTE: the latched request is not reset; every use is qualified by the FSM state.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_port   <= w_grant1;
            r_addr   <= w_in_addr;
            r_size   <= w_in_size;
            r_write  <= w_grant1 ? p1_req_write : p0_req_write;
            r_signed <= w_in_signed;
            r_wdata  <= w_grant1 ? p1_req_wdata : p0_req_wdata;
            r_err    <= !w_f_legal;
        end
    end

    assign p0_req_ready = w_grant0;
    assign p1_req_ready = w_grant1;

    assign w_mem     = (r_state == ST_MEM);
    assign w_store   = w_mem && r_write;
    assign mem_en    = w_mem;
    assign mem_we    = w_store;
    assign mem_addr  = w_mem ? r_addr[ADDR_W-1:2] : '0;
    assign mem_be    = w_store ? w_f_be : 4'b0000;
    assign mem_wdata = w_store ? w_f_wdata : 32'd0;

    // A reset landing on RESP suppresses the response pulse.
    assign w_rsp      = (r_state == ST_RESP) && !rst;
    assign w_rsp_data = w_rsp && !r_write && !r_err;

    assign p0_rsp_valid = w_rsp && !r_port;
    assign p1_rsp_valid = w_rsp &&  r_port;
    assign p0_rsp_err   = p0_rsp_valid && r_err;
    assign p1_rsp_err   = p1_rsp_valid && r_err;
    assign p0_rsp_rdata = (w_rsp_data && !r_port) ? w_f_rdata : 32'd0;
    assign p1_rsp_rdata = (w_rsp_data &&  r_port) ? w_f_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural RAM.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req_valid = 1'b0, p1_req_valid = 1'b0;
    logic        p0_req_ready, p1_req_ready;
    logic [7:0]  p0_req_addr = '0, p1_req_addr = '0;
    logic [2:0]  p0_req_size = '0, p1_req_size = '0;
    logic        p0_req_write = 1'b0, p1_req_write = 1'b0;
    logic        p0_req_signed = 1'b0, p1_req_signed = 1'b0;
    logic [31:0] p0_req_wdata = '0, p1_req_wdata = '0;
    logic        p0_rsp_valid, p1_rsp_valid;
    logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
    logic        p0_rsp_err, p1_rsp_err;
    logic        mem_en, mem_we;
    logic [5:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] ram [0:63];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
        .p0_req_size(p0_req_size), .p0_req_write(p0_req_write), .p0_req_signed(p0_req_signed),
        .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
        .p1_req_size(p1_req_size), .p1_req_write(p1_req_write), .p1_req_signed(p1_req_signed),
        .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .p1_rsp_err(p1_rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM model: read data valid the cycle after mem_en; preload on reset.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
        if (rst) begin
            ram[2] <= 32'hDEADBEEF;
            ram[3] <= 32'h80017FFF;
            ram[4] <= 32'h00000000;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
    endtask

    task automatic req(input int port, input logic [7:0] addr, input logic [2:0] size,
                       input logic write, input logic sgn, input logic [31:0] wdata);
        if (port == 0) begin
            p0_req_valid = 1'b1; p0_req_addr = addr; p0_req_size = size;
            p0_req_write = write; p0_req_signed = sgn; p0_req_wdata = wdata;
        end else begin
            p1_req_valid = 1'b1; p1_req_addr = addr; p1_req_size = size;
            p1_req_write = write; p1_req_signed = sgn; p1_req_wdata = wdata;
        end
    endtask

    // Single-port transaction with cycle-exact checks of grant, MEM and response.
    task automatic do_txn(input string tag, input int port, input logic [7:0] addr,
                          input logic [2:0] size, input logic sgn,
                          input logic [31:0] exp_rdata, input logic exp_err);
        req(port, addr, size, 1'b0, sgn, 32'd0);
        #1;
        chk({tag, "_ready"}, (port == 0) ? p0_req_ready : p1_req_ready, 32'd1);
        tick();
        drop();
        if (!exp_err) begin
            chk({tag, "_mem_en"}, mem_en, 32'd1);
            chk({tag, "_mem_addr"}, mem_addr, {26'd0, addr[7:2]});
            tick();
        end else begin
            chk({tag, "_no_mem_en"}, mem_en, 32'd0);
        end
        chk({tag, "_rsp_valid"}, (port == 0) ? p0_rsp_valid : p1_rsp_valid, 32'd1);
        chk({tag, "_other_rsp"}, (port == 0) ? p1_rsp_valid : p0_rsp_valid, 32'd0);
        chk({tag, "_rdata"}, (port == 0) ? p0_rsp_rdata : p1_rsp_rdata, exp_rdata);
        chk({tag, "_err"}, (port == 0) ? p0_rsp_err : p1_rsp_err, {31'd0, exp_err});
        tick();
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_p0_ready", p0_req_ready, 32'd0);
        chk("rst_p0_rsp_valid", p0_rsp_valid, 32'd0);
        chk("rst_p1_rsp_valid", p1_rsp_valid, 32'd0);
        chk("rst_p0_rsp_rdata", p0_rsp_rdata, 32'd0);
        chk("rst_mem_en", mem_en, 32'd0);
        chk("rst_mem_we", mem_we, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", mem_be, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // Both ports valid every cycle from reset: grants alternate p0, p1, p0, p1.
        req(0, 8'h08, SIZE_W, 1'b0, 1'b0, 32'd0);
        req(1, 8'h0C, SIZE_W, 1'b0, 1'b0, 32'd0);
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("rr_p0_ready", p0_req_ready, (g % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_p1_ready", p1_req_ready, (g % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("rr_mem_addr", mem_addr, (g % 2 == 1) ? 32'd3 : 32'd2);
            chk("rr_busy_ready", {31'd0, p0_req_ready | p1_req_ready}, 32'd0);
            tick();
            chk("rr_p0_rsp", p0_rsp_valid, (g % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_p1_rsp", p1_rsp_valid, (g % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_rdata", (g % 2 == 1) ? p1_rsp_rdata : p0_rsp_rdata,
                (g % 2 == 1) ? 32'h80017FFF : 32'hDEADBEEF);
            tick();
        end
        drop();
        tick();

        do_txn("ld_w08", 0, 8'h08, SIZE_W, 1'b0, 32'hDEADBEEF, 1'b0);

        // p1 store byte 0xA5 at 0x13.
        req(1, 8'h13, SIZE_B, 1'b1, 1'b0, 32'h000000A5);
        #1;
        chk("st_ready", p1_req_ready, 32'd1);
        tick();
        drop();
        chk("st_mem_en", mem_en, 32'd1);
        chk("st_mem_we", mem_we, 32'd1);
        chk("st_mem_be", mem_be, 32'h8);
        chk("st_mem_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("st_mem_addr", mem_addr, 32'h4);
        tick();
        chk("st_rsp_valid", p1_rsp_valid, 32'd1);
        chk("st_rsp_rdata", p1_rsp_rdata, 32'd0);
        chk("st_rsp_err", p1_rsp_err, 32'd0);
        tick();

        do_txn("ld_b13_s", 0, 8'h13, SIZE_B, 1'b1, 32'hFFFFFFA5, 1'b0);
        do_txn("ld_b13_u", 1, 8'h13, SIZE_B, 1'b0, 32'h000000A5, 1'b0);
        do_txn("bad_h05", 0, 8'h05, SIZE_H, 1'b0, 32'd0, 1'b1);
        do_txn("bad_sz3", 0, 8'h04, 3'b011, 1'b0, 32'd0, 1'b1);
        do_txn("ld_h0e_s", 0, 8'h0E, SIZE_H, 1'b1, 32'hFFFF8001, 1'b0);
        do_txn("ld_h0e_u", 1, 8'h0E, SIZE_H, 1'b0, 32'h00008001, 1'b0);

        // Reset during RESP of a p0 load drops the response and restores p0 priority.
        req(0, 8'h08, SIZE_W, 1'b0, 1'b0, 32'd0);
        #1;
        chk("rr_rst_ready", p0_req_ready, 32'd1);
        tick();
        drop();
        chk("rr_rst_mem_en", mem_en, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_resp_valid", p0_rsp_valid, 32'd0);
        chk("rst_resp_rdata", p0_rsp_rdata, 32'd0);
        tick();
        chk("post_rst_rsp", p0_rsp_valid, 32'd0);
        chk("post_rst_mem_en", mem_en, 32'd0);
        chk("post_rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        req(0, 8'h08, SIZE_W, 1'b0, 1'b0, 32'd0);
        req(1, 8'h0C, SIZE_W, 1'b0, 1'b0, 32'd0);
        #1;
        chk("post_rst_tie_p0", p0_req_ready, 32'd1);
        chk("post_rst_tie_p1", p1_req_ready, 32'd0);
        tick();
        drop();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
